// File: rtl/riscv_mc_ctrl_pkg.sv
// Shared widths, state encoding and control-bundle type for the multi-cycle
// RISC-V sequencing controller.
package riscv_mc_ctrl_pkg;

  localparam int unsigned REG_W   = 32;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef struct packed {
    logic imem_req;
    logic dmem_req;
    logic dmem_we;
    logic ir_we;
    logic pc_we;
    logic pc_sel;
    logic reg_we;
    logic wb_sel;
    logic halted;
    logic retire;
  } ctrl_t;

  // State entered after an instruction retires.
  function automatic state_e after_retire(input logic run);
    return run ? ST_FETCH : ST_IDLE;
  endfunction

endpackage

// File: rtl/riscv_instret_cnt.sv
// Retired-instruction counter: wraps at 2^REG_W, asynchronous clear.
module riscv_instret_cnt
  import riscv_mc_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [REG_W-1:0] count_o
);

  logic [REG_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + REG_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// handshakes, one-cycle IR/PC/RF write enables and a retire counter.
module riscv_mc_ctrl
  import riscv_mc_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_i,
  output logic               imem_req_o,
  input  logic               imem_ack_i,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  input  logic               dmem_ack_i,
  input  logic               is_load_i,
  input  logic               is_store_i,
  input  logic               is_branch_i,
  input  logic               is_jump_i,
  input  logic               is_alu_i,
  input  logic               illegal_i,
  input  logic               br_i,
  output logic               ir_we_o,
  output logic               pc_we_o,
  output logic               pc_sel_o,
  output logic               reg_we_o,
  output logic               wb_sel_o,
  output logic               halted_o,
  output logic [STATE_W-1:0] state_o,
  output logic [REG_W-1:0]   instret_o
);

  state_e state_q, state_d;
  logic   taken_q, taken_d;
  ctrl_t  ctl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      taken_q <= taken_d;
    end
  end

  // Next-state and Moore-style enable decode; everything is zero outside its state.
  always_comb begin
    state_d = state_q;
    taken_d = taken_q;
    ctl     = '0;
    case (state_q)
      ST_IDLE: begin
        if (run_i) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ctl.imem_req = 1'b1;
        if (imem_ack_i) begin
          ctl.ir_we = 1'b1;
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = illegal_i ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        taken_d = (is_branch_i & br_i) | is_jump_i;
        if (is_branch_i) begin
          ctl.pc_we  = 1'b1;
          ctl.pc_sel = br_i;
          ctl.retire = 1'b1;
          state_d    = after_retire(run_i);
        end else if (is_load_i || is_store_i) begin
          state_d = ST_MEM;
        end else if (is_alu_i || is_jump_i) begin
          state_d = ST_WB;
        end else begin
          // No class claimed the opcode: treat it like an illegal instruction.
          state_d = ST_HALT;
        end
      end
      ST_MEM: begin
        ctl.dmem_req = 1'b1;
        ctl.dmem_we  = is_store_i;
        if (dmem_ack_i) begin
          if (is_store_i) begin
            ctl.pc_we  = 1'b1;
            ctl.retire = 1'b1;
            state_d    = after_retire(run_i);
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        ctl.reg_we = 1'b1;
        ctl.wb_sel = is_load_i;
        ctl.pc_we  = 1'b1;
        ctl.pc_sel = taken_q;
        ctl.retire = 1'b1;
        state_d    = after_retire(run_i);
      end
      ST_HALT: begin
        ctl.halted = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign imem_req_o = ctl.imem_req;
  assign dmem_req_o = ctl.dmem_req;
  assign dmem_we_o  = ctl.dmem_we;
  assign ir_we_o    = ctl.ir_we;
  assign pc_we_o    = ctl.pc_we;
  assign pc_sel_o   = ctl.pc_sel;
  assign reg_we_o   = ctl.reg_we;
  assign wb_sel_o   = ctl.wb_sel;
  assign halted_o   = ctl.halted;
  assign state_o    = STATE_W'(state_q);

  riscv_instret_cnt u_instret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (ctl.retire),
    .count_o (instret_o)
  );

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed, table-driven bench for riscv_mc_ctrl: one vector per clock cycle,
// plus hand-written halt, asynchronous-reset and counter-wrap sequences.
module tb_riscv_mc_ctrl;

  logic        clk, rst_n, run_i;
  logic        imem_req_o, imem_ack_i, dmem_req_o, dmem_we_o, dmem_ack_i;
  logic        is_load_i, is_store_i, is_branch_i, is_jump_i, is_alu_i;
  logic        illegal_i, br_i;
  logic        ir_we_o, pc_we_o, pc_sel_o, reg_we_o, wb_sel_o, halted_o;
  logic [2:0]  state_o;
  logic [31:0] instret_o;

  riscv_mc_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_i       (run_i),
    .imem_req_o  (imem_req_o),
    .imem_ack_i  (imem_ack_i),
    .dmem_req_o  (dmem_req_o),
    .dmem_we_o   (dmem_we_o),
    .dmem_ack_i  (dmem_ack_i),
    .is_load_i   (is_load_i),
    .is_store_i  (is_store_i),
    .is_branch_i (is_branch_i),
    .is_jump_i   (is_jump_i),
    .is_alu_i    (is_alu_i),
    .illegal_i   (illegal_i),
    .br_i        (br_i),
    .ir_we_o     (ir_we_o),
    .pc_we_o     (pc_we_o),
    .pc_sel_o    (pc_sel_o),
    .reg_we_o    (reg_we_o),
    .wb_sel_o    (wb_sel_o),
    .halted_o    (halted_o),
    .state_o     (state_o),
    .instret_o   (instret_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decoder class: {load, store, branch, jump, alu}
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_LD   = 5'b10000;
  localparam logic [4:0] C_ST   = 5'b01000;
  localparam logic [4:0] C_BR   = 5'b00100;
  localparam logic [4:0] C_JMP  = 5'b00010;
  localparam logic [4:0] C_ALU  = 5'b00001;

  // Flags: {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we, wb_sel, halted}
  localparam logic [8:0] F_NONE  = 9'b0_0000_0000;
  localparam logic [8:0] F_IREQ  = 9'b1_0000_0000;
  localparam logic [8:0] F_DREQ  = 9'b0_1000_0000;
  localparam logic [8:0] F_DWE   = 9'b0_0100_0000;
  localparam logic [8:0] F_IRWE  = 9'b0_0010_0000;
  localparam logic [8:0] F_PCWE  = 9'b0_0001_0000;
  localparam logic [8:0] F_PCSEL = 9'b0_0000_1000;
  localparam logic [8:0] F_REGWE = 9'b0_0000_0100;
  localparam logic [8:0] F_WBSEL = 9'b0_0000_0010;
  localparam logic [8:0] F_HALT  = 9'b0_0000_0001;

  typedef struct packed {
    logic       run;
    logic       imem_ack;
    logic       dmem_ack;
    logic [4:0] cls;
    logic       ill;
    logic       br;
  } in_t;

  typedef struct packed {
    logic [2:0]  st;
    logic [8:0]  flg;
    logic [31:0] cnt;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t tbl[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   label       = 0;

  function automatic vec_t v(input logic run, input logic ia, input logic da,
                             input logic [4:0] cls, input logic ill, input logic br,
                             input logic [2:0] st, input logic [8:0] flg,
                             input logic [31:0] cnt);
    vec_t r;
    r.i.run      = run;
    r.i.imem_ack = ia;
    r.i.dmem_ack = da;
    r.i.cls      = cls;
    r.i.ill      = ill;
    r.i.br       = br;
    r.o.st       = st;
    r.o.flg      = flg;
    r.o.cnt      = cnt;
    return r;
  endfunction

  task automatic drive(input in_t i);
    run_i       = i.run;
    imem_ack_i  = i.imem_ack;
    dmem_ack_i  = i.dmem_ack;
    is_load_i   = i.cls[4];
    is_store_i  = i.cls[3];
    is_branch_i = i.cls[2];
    is_jump_i   = i.cls[1];
    is_alu_i    = i.cls[0];
    illegal_i   = i.ill;
    br_i        = i.br;
  endtask

  task automatic chk(input out_t exp);
    out_t act;
    act.st  = state_o;
    act.flg = {imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o,
               pc_sel_o, reg_we_o, wb_sel_o, halted_o};
    act.cnt = instret_o;
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL vec%0d: got state=%0d flags=%b instret=%h, expected state=%0d flags=%b instret=%h",
               label, act.st, act.flg, act.cnt, exp.st, exp.flg, exp.cnt);
    end
    label++;
  endtask

  // Drive at posedge+1, check at posedge+4, then advance to the next posedge+1.
  task automatic apply(input vec_t t);
    drive(t.i);
    #3;
    chk(t.o);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, held with an ack present
    rst_n = 1'b0;
    drive(v(0, 1, 1, C_NONE, 0, 0, 0, F_NONE, 0).i);
    #2;
    chk(v(0, 0, 0, C_NONE, 0, 0, 0, F_NONE, 32'd0).o);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    tbl.push_back(v(1, 0, 0, C_NONE, 0, 0, 0, F_NONE, 0));
    // ALU, zero-wait
    tbl.push_back(v(1, 1, 0, C_ALU, 0, 0, 1, F_IREQ | F_IRWE, 0));
    tbl.push_back(v(1, 0, 0, C_ALU, 0, 0, 2, F_NONE, 0));
    tbl.push_back(v(1, 0, 0, C_ALU, 0, 0, 3, F_NONE, 0));
    tbl.push_back(v(1, 0, 0, C_ALU, 0, 0, 5, F_REGWE | F_PCWE, 0));
    // Load, data ack after three wait cycles
    tbl.push_back(v(1, 1, 0, C_LD, 0, 0, 1, F_IREQ | F_IRWE, 1));
    tbl.push_back(v(1, 0, 0, C_LD, 0, 0, 2, F_NONE, 1));
    tbl.push_back(v(1, 0, 0, C_LD, 0, 0, 3, F_NONE, 1));
    tbl.push_back(v(1, 0, 0, C_LD, 0, 0, 4, F_DREQ, 1));
    tbl.push_back(v(1, 0, 0, C_LD, 0, 0, 4, F_DREQ, 1));
    tbl.push_back(v(1, 0, 0, C_LD, 0, 0, 4, F_DREQ, 1));
    tbl.push_back(v(1, 0, 1, C_LD, 0, 0, 4, F_DREQ, 1));
    tbl.push_back(v(1, 0, 0, C_LD, 0, 0, 5, F_REGWE | F_WBSEL | F_PCWE, 1));
    // Taken branch with one fetch wait cycle
    tbl.push_back(v(1, 0, 0, C_BR, 0, 1, 1, F_IREQ, 2));
    tbl.push_back(v(1, 1, 0, C_BR, 0, 1, 1, F_IREQ | F_IRWE, 2));
    tbl.push_back(v(1, 0, 0, C_BR, 0, 1, 2, F_NONE, 2));
    tbl.push_back(v(1, 0, 0, C_BR, 0, 1, 3, F_PCWE | F_PCSEL, 2));
    // Not-taken branch
    tbl.push_back(v(1, 1, 0, C_BR, 0, 0, 1, F_IREQ | F_IRWE, 3));
    tbl.push_back(v(1, 0, 0, C_BR, 0, 0, 2, F_NONE, 3));
    tbl.push_back(v(1, 0, 0, C_BR, 0, 0, 3, F_PCWE, 3));
    // Store, stray data ack during FETCH
    tbl.push_back(v(1, 1, 1, C_ST, 0, 0, 1, F_IREQ | F_IRWE, 4));
    tbl.push_back(v(1, 0, 0, C_ST, 0, 0, 2, F_NONE, 4));
    tbl.push_back(v(1, 0, 0, C_ST, 0, 0, 3, F_NONE, 4));
    tbl.push_back(v(1, 0, 1, C_ST, 0, 0, 4, F_DREQ | F_DWE | F_PCWE, 4));
    // Jump with run dropped in EXEC, then stray acks in IDLE
    tbl.push_back(v(1, 1, 0, C_JMP, 0, 0, 1, F_IREQ | F_IRWE, 5));
    tbl.push_back(v(1, 0, 0, C_JMP, 0, 0, 2, F_NONE, 5));
    tbl.push_back(v(0, 0, 0, C_JMP, 0, 0, 3, F_NONE, 5));
    tbl.push_back(v(0, 0, 0, C_JMP, 0, 0, 5, F_REGWE | F_PCWE | F_PCSEL, 5));
    tbl.push_back(v(0, 0, 0, C_NONE, 0, 0, 0, F_NONE, 6));
    tbl.push_back(v(0, 1, 1, C_NONE, 0, 0, 0, F_NONE, 6));
    // Branch retiring with run low parks in IDLE
    tbl.push_back(v(1, 0, 0, C_NONE, 0, 0, 0, F_NONE, 6));
    tbl.push_back(v(1, 1, 0, C_BR, 0, 1, 1, F_IREQ | F_IRWE, 6));
    tbl.push_back(v(1, 0, 0, C_BR, 0, 1, 2, F_NONE, 6));
    tbl.push_back(v(0, 0, 0, C_BR, 0, 1, 3, F_PCWE | F_PCSEL, 6));
    tbl.push_back(v(0, 0, 0, C_NONE, 0, 0, 0, F_NONE, 7));

    foreach (tbl[k]) apply(tbl[k]);

    // Illegal opcode: HALT absorbs run and acks for 20 cycles
    apply(v(1, 0, 0, C_NONE, 0, 0, 0, F_NONE, 7));
    apply(v(1, 1, 0, C_ALU, 0, 0, 1, F_IREQ | F_IRWE, 7));
    apply(v(1, 0, 0, C_ALU, 1, 0, 2, F_NONE, 7));
    for (int n = 0; n < 20; n++) begin
      apply(v(1, 1, 1, C_ALU, 0, 0, 6, F_HALT, 7));
    end
    drive(v(0, 0, 0, C_NONE, 0, 0, 0, F_NONE, 0).i);
    rst_n = 1'b0;
    #1;
    chk(v(0, 0, 0, C_NONE, 0, 0, 0, F_NONE, 0).o);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Counter wrap, with run dropped during EXEC of a jump
    force dut.u_instret.count_q = 32'hFFFF_FFFF;
    #1 release dut.u_instret.count_q;
    apply(v(0, 0, 0, C_NONE, 0, 0, 0, F_NONE, 32'hFFFF_FFFF));
    apply(v(1, 0, 0, C_JMP, 0, 0, 0, F_NONE, 32'hFFFF_FFFF));
    apply(v(1, 1, 0, C_JMP, 0, 0, 1, F_IREQ | F_IRWE, 32'hFFFF_FFFF));
    apply(v(1, 0, 0, C_JMP, 0, 0, 2, F_NONE, 32'hFFFF_FFFF));
    apply(v(0, 0, 0, C_JMP, 0, 0, 3, F_NONE, 32'hFFFF_FFFF));
    apply(v(0, 0, 0, C_JMP, 0, 0, 5, F_REGWE | F_PCWE | F_PCSEL, 32'hFFFF_FFFF));
    apply(v(0, 0, 0, C_NONE, 0, 0, 0, F_NONE, 32'd0));

    // Reset during a pending store drops the request without a clock edge
    apply(v(1, 0, 0, C_ST, 0, 0, 0, F_NONE, 0));
    apply(v(1, 1, 0, C_ST, 0, 0, 1, F_IREQ | F_IRWE, 0));
    apply(v(1, 0, 0, C_ST, 0, 0, 2, F_NONE, 0));
    apply(v(1, 0, 0, C_ST, 0, 0, 3, F_NONE, 0));
    apply(v(1, 0, 0, C_ST, 0, 0, 4, F_DREQ | F_DWE, 0));
    drive(v(0, 0, 0, C_ST, 0, 0, 0, F_NONE, 0).i);
    #1 rst_n = 1'b0;
    #1;
    chk(v(0, 0, 0, C_ST, 0, 0, 0, F_NONE, 0).o);
    #3 rst_n = 1'b1;
    apply(v(0, 0, 1, C_ST, 0, 0, 0, F_NONE, 0));
    apply(v(0, 0, 1, C_ST, 0, 0, 0, F_NONE, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
